// File: rtl/aximm_patchkr.sv
// rtl/aximm_patchkr.sv - receive-side pattern checker with expected-data FIFO
module aximm_patchkr #(
  parameter int AXI_CHNL_NUM = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = 16,
  localparam int DATA_W      = AXI_CHNL_NUM * 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chk_en,
  input  logic              cntuspatt_en,
  input  logic [7:0]        chk_cnt,
  input  logic              exp_wr,
  input  logic [DATA_W-1:0] exp_din,
  output logic              chkr_fifo_full,
  input  logic              axist_valid,
  output logic              axist_rdy,
  input  logic [DATA_W-1:0] axist_din,
  output logic              chk_busy,
  output logic              chk_done,
  output logic              chk_pass,
  output logic [CNT_W-1:0]  rx_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic              exp_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       fifo_cnt;
  logic              fifo_empty;
  logic              push;
  logic              hs;
  logic              last_acc;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  chk_cnt_ext;
  logic              cmp_vld;
  logic              mis;

  assign chk_cnt_ext    = CNT_W'(chk_cnt);
  assign fifo_empty     = (fifo_cnt == '0);
  assign chkr_fifo_full = (fifo_cnt == FULL_CNT);
  assign push           = exp_wr & ~chkr_fifo_full;
  // A zero chk_cnt in counted mode makes last_acc true from the first CHECK cycle.
  assign last_acc       = ~cntuspatt_en & (acc_cnt == chk_cnt_ext);
  assign axist_rdy      = (state == S_CHECK) & ~fifo_empty & ~last_acc;
  assign hs             = axist_valid & axist_rdy;
  assign chk_busy       = (state == S_CHECK) | (state == S_DRAIN);
  assign chk_done       = (state == S_DONE);

  // Expected-word storage; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= exp_din;
    end
  end

  // FIFO pointers and occupancy; pushes are accepted in every state, pops only on handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (hs)   rd_ptr <= rd_ptr + 1'b1;
      case ({push, hs})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // One-cycle compare stage: capture the mismatch flag against the head being popped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_vld <= 1'b0;
      mis     <= 1'b0;
    end else begin
      cmp_vld <= hs;
      if (hs) mis <= (axist_din != mem[rd_ptr]);
    end
  end

  // Run control plus statistics; counters trail the handshake by the compare stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      acc_cnt       <= '0;
      rx_cnt        <= '0;
      err_cnt       <= '0;
      first_err_idx <= '1;
      exp_ovf       <= 1'b0;
      chk_pass      <= 1'b0;
    end else begin
      if (hs && acc_cnt != CNT_MAX) acc_cnt <= acc_cnt + 1'b1;
      if (cmp_vld) begin
        if (rx_cnt != CNT_MAX) rx_cnt <= rx_cnt + 1'b1;
        if (mis) begin
          if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
          if (err_cnt == '0) first_err_idx <= rx_cnt;
        end
      end
      if (exp_wr && chkr_fifo_full) exp_ovf <= 1'b1;

      case (state)
        S_IDLE: begin
          if (chk_en) begin
            state         <= S_CHECK;
            acc_cnt       <= '0;
            rx_cnt        <= '0;
            err_cnt       <= '0;
            first_err_idx <= '1;
            // An overflow coinciding with arming still belongs to the new run.
            exp_ovf       <= exp_wr & chkr_fifo_full;
            chk_pass      <= 1'b0;
          end
        end
        S_CHECK: begin
          if (last_acc || !chk_en) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!cmp_vld) begin
            state    <= S_DONE;
            chk_pass <= (err_cnt == '0) & ~exp_ovf &
                        (cntuspatt_en | (rx_cnt == chk_cnt_ext));
          end
        end
        S_DONE: begin
          if (!chk_en) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aximm_patchkr.sv
// tb/tb_aximm_patchkr.sv - self-checking bench for aximm_patchkr
module tb_aximm_patchkr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        chk_en;
  logic        cntuspatt_en;
  logic [7:0]  chk_cnt;
  logic        exp_wr;
  logic [63:0] exp_din;
  logic        chkr_fifo_full;
  logic        axist_valid;
  logic        axist_rdy;
  logic [63:0] axist_din;
  logic        chk_busy;
  logic        chk_done;
  logic        chk_pass;
  logic [15:0] rx_cnt;
  logic [15:0] err_cnt;
  logic [15:0] first_err_idx;
  logic        exp_ovf;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int pi;
  int si;
  logic [63:0] words_q[$];
  logic [63:0] beats_q[$];

  aximm_patchkr dut (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .cntuspatt_en(cntuspatt_en),
    .chk_cnt(chk_cnt), .exp_wr(exp_wr), .exp_din(exp_din),
    .chkr_fifo_full(chkr_fifo_full), .axist_valid(axist_valid),
    .axist_rdy(axist_rdy), .axist_din(axist_din), .chk_busy(chk_busy),
    .chk_done(chk_done), .chk_pass(chk_pass), .rx_cnt(rx_cnt),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx), .exp_ovf(exp_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; chk_en = 1'b0; cntuspatt_en = 1'b0; chk_cnt = 8'd0;
    exp_wr = 1'b0; exp_din = '0; axist_valid = 1'b0; axist_din = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!chk_done && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(tag, chk_done, 1'b1);
  endtask

  // Pushes words_q and offers beats_q with random gaps; stops after n_beats handshakes.
  task automatic stream(input int n_beats);
    int cyc = 0;
    bit push_ok;
    bit hs;
    pi = 0;
    si = 0;
    while ((pi < words_q.size() || si < n_beats) && cyc < 4000) begin
      exp_wr      = (pi < words_q.size()) && !chkr_fifo_full && ($urandom_range(0, 3) != 0);
      exp_din     = (pi < words_q.size()) ? words_q[pi] : 64'd0;
      axist_valid = (si < n_beats) && ($urandom_range(0, 3) != 0);
      axist_din   = (si < n_beats) ? beats_q[si] : 64'd0;
      push_ok     = exp_wr;
      hs          = axist_valid && axist_rdy;
      @(negedge clk);
      if (push_ok) pi++;
      if (hs) si++;
      cyc++;
    end
    exp_wr = 1'b0;
    axist_valid = 1'b0;
    check("stream_timeout", 64'(cyc < 4000), 64'd1);
  endtask

  // Reference verdict: beat k is compared with the k-th expected word in push order.
  task automatic check_verdict(input string tag, input bit cont, input int ccnt, input bit ovf);
    int e = 0;
    int first = -1;
    bit pass;
    for (int k = 0; k < si; k++) begin
      if (beats_q[k] !== words_q[k]) begin
        if (first < 0) first = k;
        e++;
      end
    end
    pass = (e == 0) && !ovf && (cont || si == ccnt);
    check({tag, "_busy"}, chk_busy, 1'b0);
    check({tag, "_rx"}, rx_cnt, 64'(si));
    check({tag, "_err"}, err_cnt, 64'(e));
    check({tag, "_first"}, first_err_idx, (first < 0) ? 64'hFFFF : 64'(first));
    check({tag, "_pass"}, chk_pass, 64'(pass));
    check({tag, "_ovf"}, exp_ovf, 64'(ovf));
  endtask

  task automatic fill_random(input int n, input int err_pct);
    logic [63:0] w;
    words_q.delete();
    beats_q.delete();
    for (int k = 0; k < n; k++) begin
      w = {$urandom(), $urandom()};
      words_q.push_back(w);
      if ($urandom_range(0, 99) < err_pct) beats_q.push_back(w ^ (64'd1 << $urandom_range(0, 63)));
      else beats_q.push_back(w);
    end
  endtask

  initial begin
    int n;
    bit cont;
    do_reset();
    check("rst_busy", chk_busy, 1'b0);
    check("rst_done", chk_done, 1'b0);
    check("rst_pass", chk_pass, 1'b0);
    check("rst_rx", rx_cnt, 64'd0);
    check("rst_err", err_cnt, 64'd0);
    check("rst_first", first_err_idx, 64'hFFFF);
    check("rst_full", chkr_fifo_full, 1'b0);
    check("rst_rdy", axist_rdy, 1'b0);
    check("rst_ovf", exp_ovf, 1'b0);

    // Directed: 8 matching beats.
    words_q.delete(); beats_q.delete();
    for (int k = 0; k < 8; k++) begin
      words_q.push_back(64'h11 + 64'(k));
      beats_q.push_back(64'h11 + 64'(k));
    end
    chk_cnt = 8'd8; chk_en = 1'b1;
    stream(8);
    wait_done("t1_done");
    check_verdict("t1", 1'b0, 8, 1'b0);
    chk_en = 1'b0;
    @(negedge clk);
    check("t1_idle", chk_done, 1'b0);

    // Directed: beat 3 corrupted.
    beats_q[3] = 64'hFF;
    chk_en = 1'b1;
    stream(8);
    wait_done("t2_done");
    check_verdict("t2", 1'b0, 8, 1'b0);
    check("t2_first3", first_err_idx, 64'd3);
    chk_en = 1'b0;
    @(negedge clk);

    // Overflow: 17 back-to-back pushes with no receive traffic.
    chk_cnt = 8'd8; chk_en = 1'b1;
    for (int k = 0; k < 17; k++) begin
      exp_wr = 1'b1; exp_din = 64'(k);
      @(negedge clk);
      if (k == 15) begin
        check("t3_full16", chkr_fifo_full, 1'b1);
        check("t3_noovf16", exp_ovf, 1'b0);
      end
    end
    exp_wr = 1'b0;
    check("t3_ovf", exp_ovf, 1'b1);
    chk_en = 1'b0;
    wait_done("t3_done");
    check("t3_pass", chk_pass, 1'b0);
    check("t3_rx", rx_cnt, 64'd0);
    do_reset();

    // Empty FIFO holds ready low; one push raises it on the next cycle.
    chk_cnt = 8'd2; chk_en = 1'b1; axist_valid = 1'b1; axist_din = 64'h55;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_rdy_low", axist_rdy, 1'b0);
    end
    check("t4_rx0", rx_cnt, 64'd0);
    exp_wr = 1'b1; exp_din = 64'h55;
    @(negedge clk);
    exp_wr = 1'b0;
    check("t4_rdy_high", axist_rdy, 1'b1);
    axist_valid = 1'b0;
    chk_en = 1'b0;
    wait_done("t4_done");
    check("t4_rx", rx_cnt, 64'd0);
    check("t4_pass", chk_pass, 1'b0);
    do_reset();

    // chk_cnt of zero: no beats accepted, clean pass.
    chk_cnt = 8'd0; chk_en = 1'b1; exp_wr = 1'b1; exp_din = 64'h1;
    @(negedge clk);
    exp_wr = 1'b0; axist_valid = 1'b1;
    wait_done("t0_done");
    check("t0_rx", rx_cnt, 64'd0);
    check("t0_pass", chk_pass, 1'b1);
    axist_valid = 1'b0; chk_en = 1'b0;
    do_reset();

    // Continuous mode, 300 matching beats.
    fill_random(300, 0);
    cntuspatt_en = 1'b1; chk_en = 1'b1;
    stream(300);
    chk_en = 1'b0;
    wait_done("t5_done");
    check_verdict("t5", 1'b1, 0, 1'b0);
    @(negedge clk);

    // Randomized runs, alternating counted and continuous mode.
    for (int r = 0; r < 6; r++) begin
      cont = r[0];
      n = $urandom_range(1, 40);
      fill_random(n, (r >= 2) ? 15 : 0);
      cntuspatt_en = cont; chk_cnt = 8'(n); chk_en = 1'b1;
      stream(n);
      if (cont) chk_en = 1'b0;
      wait_done("rnd_done");
      check_verdict("rnd", cont, n, 1'b0);
      chk_en = 1'b0;
      @(negedge clk);
    end

    // Reset in the middle of an 8-beat run.
    do_reset();
    fill_random(8, 0);
    chk_cnt = 8'd8; chk_en = 1'b1;
    stream(4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_busy", chk_busy, 1'b0);
    check("t6_done", chk_done, 1'b0);
    check("t6_rx", rx_cnt, 64'd0);
    check("t6_err", err_cnt, 64'd0);
    check("t6_first", first_err_idx, 64'hFFFF);
    check("t6_full", chkr_fifo_full, 1'b0);
    check("t6_rdy", axist_rdy, 1'b0);
    axist_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_rearm_busy", chk_busy, 1'b1);
    check("t6_empty_rdy", axist_rdy, 1'b0);
    axist_valid = 1'b0; chk_en = 1'b0;
    wait_done("t6_abort_done");
    check("t6_abort_pass", chk_pass, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
